// File: rtl/cache_line_fill.sv
// ---------------------------------------------------------------------------
// cache_line_fill
//   Write side of the cache tag/valid store. Owns the per-way valid bit
//   arrays read by the hit detector. On an accepted miss, the block picks a
//   victim way, fetches BEATS data beats over a req/ack bus, and writes each
//   beat to the line RAM. It then writes the tag and sets the valid bit.
//   It also services single-index and whole-cache invalidates in any state.
//
//   Optional feature macro: CACHE_FILL_CRITICAL_FIRST_EN
//     defined   : first beat fetched is the beat holding miss_adr, order wraps
//     undefined : beats are always fetched 0..BEATS-1
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   miss_req/miss_adr     fill request, accepted when miss_req && miss_ready
//   miss_ready            idle, able to accept a fill
//   mem_req/mem_adr       beat read request and beat address
//   mem_ack/mem_err/mem_dat  beat response, error aborts the fill
//   line_we/line_way/line_ndx/line_beat/line_dat  line RAM write port
//   tag_we/tag_out        tag RAM write port (at {line_way,line_ndx})
//   valid                 valid bits, [way][index]
//   inv_line/inv_adr      invalidate one index in all ways
//   inv_all               invalidate every line
//   fill_done/fill_err    one-cycle completion / abort pulses
// ---------------------------------------------------------------------------
module cache_line_fill #(
  parameter int LINES  = 256,
  parameter int WAYS   = 4,
  parameter int AWID   = 32,
  parameter int TAGBIT = 14,
  parameter int BEATS  = 4,
  parameter int DWID   = 128
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       miss_req,
  input  logic [AWID-1:0]            miss_adr,
  output logic                       miss_ready,
  output logic                       mem_req,
  output logic [AWID-1:0]            mem_adr,
  input  logic                       mem_ack,
  input  logic                       mem_err,
  input  logic [DWID-1:0]            mem_dat,
  output logic                       line_we,
  output logic [1:0]                 line_way,
  output logic [$clog2(LINES)-1:0]   line_ndx,
  output logic [$clog2(BEATS)-1:0]   line_beat,
  output logic [DWID-1:0]            line_dat,
  output logic                       tag_we,
  output logic [AWID-TAGBIT-1:0]     tag_out,
  output logic [WAYS-1:0][LINES-1:0] valid,
  input  logic                       inv_line,
  input  logic [AWID-1:0]            inv_adr,
  input  logic                       inv_all,
  output logic                       fill_done,
  output logic                       fill_err
);

  localparam int NDXW  = $clog2(LINES);
  localparam int BEATW = $clog2(BEATS);
  localparam int BYTEW = $clog2(DWID/8);
  localparam int OFFW  = TAGBIT - NDXW;   // byte offset within a line
  localparam int LADRW = AWID - OFFW;     // line address = {tag, index}

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_TAGWR = 2'd2
  } state_t;

  state_t                    r_state;
  logic [LADRW-1:0]          r_line_adr;
  logic [1:0]                r_way;
  logic [1:0]                r_rr;
  logic [BEATW-1:0]          r_beat;      // slot of the beat being requested
  logic [BEATW-1:0]          r_cnt;       // number of beats already received
  logic                      r_poison;
  logic                      r_miss_ready;
  logic                      r_mem_req;
  logic                      r_line_we;
  logic [BEATW-1:0]          r_line_beat;
  logic [DWID-1:0]           r_line_dat;
  logic                      r_tag_we;
  logic                      r_fill_done;
  logic                      r_fill_err;
  logic [WAYS-1:0][LINES-1:0] r_valid;

  logic [NDXW-1:0]           w_miss_ndx;
  logic [NDXW-1:0]           w_inv_ndx;
  logic [NDXW-1:0]           w_fill_ndx;
  logic [BEATW-1:0]          w_start_beat;
  logic [WAYS-1:0]           w_way_valid;
  logic                      w_free_found;
  logic [1:0]                w_free_way;
  logic [1:0]                w_victim;
  logic [1:0]                w_rr_next;
  logic                      w_accept;
  logic                      w_busy;
  logic                      w_poison_now;
  logic                      w_unused_bits;

  assign w_miss_ndx = miss_adr[TAGBIT-1 -: NDXW];
  assign w_inv_ndx  = inv_adr[TAGBIT-1 -: NDXW];
  assign w_fill_ndx = r_line_adr[NDXW-1:0];

`ifdef CACHE_FILL_CRITICAL_FIRST_EN
  assign w_start_beat = miss_adr[OFFW-1 -: BEATW];
`else
  assign w_start_beat = '0;
`endif

  // Offset bits of the request and the non-index bits of the invalidate
  // address carry no meaning for this block.
  assign w_unused_bits = ^{miss_adr[OFFW-1:0], inv_adr[AWID-1:TAGBIT], inv_adr[OFFW-1:0]};

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way_valid
    assign w_way_valid[gi] = r_valid[gi][w_miss_ndx];
  end

  // Lowest invalid way wins; scanning downward leaves the lowest one last.
  always_comb begin
    w_free_found = 1'b0;
    w_free_way   = 2'd0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!w_way_valid[w]) begin
        w_free_found = 1'b1;
        w_free_way   = 2'(w);
      end
    end
  end

  assign w_rr_next = (r_rr == 2'(WAYS - 1)) ? 2'd0 : r_rr + 2'd1;
  assign w_victim  = w_free_found ? w_free_way : r_rr;
  assign w_accept  = miss_req && r_miss_ready;
  assign w_busy    = (r_state != S_IDLE);
  // An invalidate that touches the line being filled must keep it invalid
  // even though the fill itself runs to completion.
  assign w_poison_now = w_busy && (inv_all || (inv_line && (w_inv_ndx == w_fill_ndx)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_line_adr   <= '0;
      r_way        <= 2'd0;
      r_rr         <= 2'd0;
      r_beat       <= '0;
      r_cnt        <= '0;
      r_poison     <= 1'b0;
      r_miss_ready <= 1'b1;
      r_mem_req    <= 1'b0;
      r_line_we    <= 1'b0;
      r_line_beat  <= '0;
      r_line_dat   <= '0;
      r_tag_we     <= 1'b0;
      r_fill_done  <= 1'b0;
      r_fill_err   <= 1'b0;
      r_valid      <= '0;
    end else begin
      r_line_we   <= 1'b0;
      r_tag_we    <= 1'b0;
      r_fill_done <= 1'b0;
      r_fill_err  <= 1'b0;
      if (w_poison_now) begin
        r_poison <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_line_adr   <= miss_adr[AWID-1:OFFW];
            r_way        <= w_victim;
            if (!w_free_found) begin
              r_rr <= w_rr_next;
            end
            r_beat       <= w_start_beat;
            r_cnt        <= '0;
            r_poison     <= 1'b0;
            r_mem_req    <= 1'b1;
            r_miss_ready <= 1'b0;
            r_state      <= S_FETCH;
            r_valid[w_victim][w_miss_ndx] <= 1'b0;
          end
        end
        S_FETCH: begin
          if (mem_err) begin
            // Error wins over a simultaneous ack; victim stays invalid.
            r_mem_req    <= 1'b0;
            r_fill_err   <= 1'b1;
            r_miss_ready <= 1'b1;
            r_state      <= S_IDLE;
          end else if (mem_ack) begin
            r_line_we   <= 1'b1;
            r_line_dat  <= mem_dat;
            r_line_beat <= r_beat;
            r_beat      <= r_beat + BEATW'(1);
            r_cnt       <= r_cnt + BEATW'(1);
            if (r_cnt == BEATW'(BEATS - 1)) begin
              r_mem_req   <= 1'b0;
              r_tag_we    <= 1'b1;
              r_fill_done <= 1'b1;
              r_state     <= S_TAGWR;
            end
          end
        end
        S_TAGWR: begin
          if (!r_poison) begin
            r_valid[r_way][w_fill_ndx] <= 1'b1;
          end
          r_miss_ready <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Invalidates come last so they override a same-edge set.
      if (inv_all) begin
        r_valid <= '0;
      end else if (inv_line) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[w][w_inv_ndx] <= 1'b0;
        end
      end
    end
  end

  assign miss_ready = r_miss_ready;
  assign mem_req    = r_mem_req;
  assign mem_adr    = {r_line_adr, r_beat, {BYTEW{1'b0}}};
  assign line_we    = r_line_we;
  assign line_way   = r_way;
  assign line_ndx   = w_fill_ndx;
  assign line_beat  = r_line_beat;
  assign line_dat   = r_line_dat;
  assign tag_we     = r_tag_we;
  assign tag_out    = r_line_adr[LADRW-1:NDXW];
  assign valid      = r_valid;
  assign fill_done  = r_fill_done;
  assign fill_err   = r_fill_err;

endmodule
